// File: rtl/prog_loader.sv
// Framed byte-stream loader: assembles instruction words, writes them into
// program memory, and holds the CPU in reset until the frame checksum verifies.
module prog_loader #(
    parameter logic [7:0] HEADER = 8'hA5,
    parameter int         AW     = 11,
    parameter int         DW     = 14
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [7:0]    in_data,
    output logic          in_ready,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic [DW-1:0] wr_data,
    output logic          cpu_rst,
    output logic          done,
    output logic          err
);

    typedef enum logic [2:0] {
        IDLE, CNT_H, CNT_L, DATA_H, DATA_L, CHK, RUN, ERR
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   count_q, count_d;
    logic [AW-1:0]   word_q, word_d;
    logic [DW-9:0]   hi_q, hi_d;
    logic [7:0]      acc_q, acc_d;
    logic            wr_en_q, wr_en_d;
    logic [AW-1:0]   wr_addr_q, wr_addr_d;
    logic [DW-1:0]   wr_data_q, wr_data_d;
    logic            cpu_rst_q, cpu_rst_d;
    logic            done_q, done_d;
    logic            err_q, err_d;
    logic [AW-1:0]   count_full;

    // The loader never back-pressures; every valid byte is consumed.
    assign in_ready   = 1'b1;
    assign count_full = {count_q[AW-1:8], in_data};

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        word_d    = word_q;
        hi_d      = hi_q;
        acc_d     = acc_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;

        if (in_valid) begin
            case (state_q)
                IDLE, RUN, ERR: begin
                    if (in_data == HEADER) begin
                        state_d = CNT_H;
                        acc_d   = 8'h00;
                    end
                end
                CNT_H: begin
                    acc_d   = acc_q ^ in_data;
                    count_d = {in_data[AW-9:0], 8'h00};
                    state_d = (in_data[7:AW-8] != '0) ? ERR : CNT_L;
                end
                CNT_L: begin
                    acc_d     = acc_q ^ in_data;
                    count_d   = count_full;
                    word_d    = '0;
                    wr_addr_d = '0;
                    state_d   = (count_full == '0) ? CHK : DATA_H;
                end
                DATA_H: begin
                    acc_d   = acc_q ^ in_data;
                    hi_d    = in_data[DW-9:0];
                    state_d = DATA_L;
                end
                DATA_L: begin
                    acc_d     = acc_q ^ in_data;
                    wr_en_d   = 1'b1;
                    wr_addr_d = word_q;
                    wr_data_d = {hi_q, in_data};
                    word_d    = word_q + AW'(1);
                    state_d   = (word_q == count_q - AW'(1)) ? CHK : DATA_H;
                end
                CHK: begin
                    state_d = (in_data == acc_q) ? RUN : ERR;
                end
                default: state_d = IDLE;
            endcase
        end

        // Status outputs are registered copies of the next state.
        cpu_rst_d = (state_d != RUN);
        done_d    = (state_d == RUN);
        err_d     = (state_d == ERR);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            count_q   <= '0;
            word_q    <= '0;
            hi_q      <= '0;
            acc_q     <= 8'h00;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            cpu_rst_q <= 1'b1;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            word_q    <= word_d;
            hi_q      <= hi_d;
            acc_q     <= acc_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            cpu_rst_q <= cpu_rst_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign wr_en   = wr_en_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;
    assign cpu_rst = cpu_rst_q;
    assign done    = done_q;
    assign err     = err_q;

endmodule

// File: tb/tb_prog_loader.sv
// Directed table-driven bench for prog_loader plus gapped-stream and
// maximum-count frame sequences.
module tb_prog_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        wr_en;
    logic [10:0] wr_addr;
    logic [13:0] wr_data;
    logic        cpu_rst;
    logic        done;
    logic        err;

    int checks = 0;
    int errors = 0;

    prog_loader dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .cpu_rst  (cpu_rst),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [7:0]  d;
        logic        r;
        logic        we;
        logic [10:0] a;
        logic [13:0] wd;
        logic        cr;
        logic        dn;
        logic        er;
    } vec_t;

    vec_t rows[$];

    task automatic add(input logic v, input logic [7:0] d, input logic r,
                       input logic we, input logic [10:0] a, input logic [13:0] wd,
                       input logic cr, input logic dn, input logic er);
        rows.push_back('{v, d, r, we, a, wd, cr, dn, er});
    endtask

    // Accepted byte, no write expected.
    task automatic b(input logic [7:0] d, input logic cr, input logic dn, input logic er);
        add(1'b1, d, 1'b0, 1'b0, 11'd0, 14'd0, cr, dn, er);
    endtask

    // Accepted DATA_L byte, write expected; loader still mid-frame.
    task automatic w(input logic [7:0] d, input logic [10:0] a, input logic [13:0] wd);
        add(1'b1, d, 1'b0, 1'b1, a, wd, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic normal_frame();
        b(8'hA5, 1, 0, 0); b(8'h00, 1, 0, 0); b(8'h02, 1, 0, 0); b(8'h30, 1, 0, 0);
        w(8'h05, 11'd0, 14'h3005); b(8'h28, 1, 0, 0);
        w(8'h00, 11'd1, 14'h2800); b(8'h1F, 0, 1, 0);
    endtask

    task automatic chk(input string name, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s #%0d: got %h expected %h", name, idx, act, exp);
        end
    endtask

    task automatic step(input logic v, input logic [7:0] d, input logic r);
        in_valid = v;
        in_data  = d;
        rst      = r;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0]  gap_bytes [10];
        logic [10:0] exp_a [2];
        logic [13:0] exp_d [2];
        int          nw;
        logic [7:0]  acc;
        logic [7:0]  hi;
        logic [7:0]  lo;
        logic [13:0] word;

        in_valid = 1'b0;
        in_data  = 8'h00;
        rst      = 1'b1;

        // Table: each row is one clock; outputs checked just after the edge.
        normal_frame();
        add(1'b0, 8'hA5, 1'b0, 1'b0, 11'd0, 14'd0, 0, 1, 0);
        b(8'h33, 0, 1, 0);
        // Reload while running.
        b(8'hA5, 1, 0, 0); b(8'h00, 1, 0, 0); b(8'h01, 1, 0, 0); b(8'h3E, 1, 0, 0);
        w(8'h07, 11'd0, 14'h3E07); b(8'h38, 0, 1, 0);
        // Bad checksum.
        b(8'hA5, 1, 0, 0); b(8'h00, 1, 0, 0); b(8'h02, 1, 0, 0); b(8'h30, 1, 0, 0);
        w(8'h05, 11'd0, 14'h3005); b(8'h28, 1, 0, 0);
        w(8'h00, 11'd1, 14'h2800); b(8'h1E, 1, 0, 1);
        // Zero count from ERR.
        b(8'hA5, 1, 0, 0); b(8'h00, 1, 0, 0); b(8'h00, 1, 0, 0); b(8'h00, 0, 1, 0);
        // Bad count; trailing bytes dropped.
        b(8'hA5, 1, 0, 0); b(8'h08, 1, 0, 1);
        b(8'h05, 1, 0, 1); b(8'h28, 1, 0, 1); b(8'h00, 1, 0, 1); b(8'hFF, 1, 0, 1);
        // HEADER value inside data; DATA_H bits [7:6] ignored.
        b(8'hA5, 1, 0, 0); b(8'h00, 1, 0, 0); b(8'h01, 1, 0, 0); b(8'hA5, 1, 0, 0);
        w(8'hA5, 11'd0, 14'h25A5); b(8'h01, 0, 1, 0);
        // Reset mid-frame after DATA_H, then a full reload.
        b(8'hA5, 1, 0, 0); b(8'h00, 1, 0, 0); b(8'h01, 1, 0, 0); b(8'h3E, 1, 0, 0);
        add(1'b1, 8'h07, 1'b1, 1'b0, 11'd0, 14'd0, 1, 0, 0);
        b(8'h07, 1, 0, 0);
        normal_frame();

        // Reset state.
        step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b1);
        chk("reset_wr_en",   0, 32'(wr_en),   32'd0);
        chk("reset_wr_addr", 0, 32'(wr_addr), 32'd0);
        chk("reset_wr_data", 0, 32'(wr_data), 32'd0);
        chk("reset_cpu_rst", 0, 32'(cpu_rst), 32'd1);
        chk("reset_done",    0, 32'(done),    32'd0);
        chk("reset_err",     0, 32'(err),     32'd0);
        chk("reset_ready",   0, 32'(in_ready), 32'd1);

        for (int i = 0; i < rows.size(); i++) begin
            step(rows[i].v, rows[i].d, rows[i].r);
            $display("row %0d v=%0b d=%h r=%0b -> wr_en=%0b addr=%0d data=%h cpu_rst=%0b done=%0b err=%0b",
                     i, rows[i].v, rows[i].d, rows[i].r, wr_en, wr_addr, wr_data, cpu_rst, done, err);
            chk("wr_en", i, 32'(wr_en), 32'(rows[i].we));
            if (rows[i].we) begin
                chk("wr_addr", i, 32'(wr_addr), 32'(rows[i].a));
                chk("wr_data", i, 32'(wr_data), 32'(rows[i].wd));
            end
            chk("cpu_rst",  i, 32'(cpu_rst), 32'(rows[i].cr));
            chk("done",     i, 32'(done),    32'(rows[i].dn));
            chk("err",      i, 32'(err),     32'(rows[i].er));
            chk("in_ready", i, 32'(in_ready), 32'd1);
        end

        // Gapped stream with leading junk, from a fresh reset.
        step(1'b0, 8'h00, 1'b1);
        gap_bytes = '{8'h00, 8'hFF, 8'hA5, 8'h00, 8'h02, 8'h30, 8'h05, 8'h28, 8'h00, 8'h1F};
        exp_a = '{11'd0, 11'd1};
        exp_d = '{14'h3005, 14'h2800};
        nw = 0;
        for (int i = 0; i < 10; i++) begin
            int gap;
            gap = int'($urandom_range(0, 5));
            for (int g = 0; g <= gap; g++) begin
                step(g == gap, (g == gap) ? gap_bytes[i] : 8'($urandom), 1'b0);
                if (wr_en) begin
                    if (nw < 2) begin
                        chk("gap_wr_addr", nw, 32'(wr_addr), 32'(exp_a[nw]));
                        chk("gap_wr_data", nw, 32'(wr_data), 32'(exp_d[nw]));
                    end
                    nw++;
                end
            end
            $display("gapped byte %0d data=%h gap=%0d writes=%0d", i, gap_bytes[i], gap, nw);
        end
        chk("gap_writes",  0, 32'(nw),      32'd2);
        chk("gap_cpu_rst", 0, 32'(cpu_rst), 32'd0);
        chk("gap_done",    0, 32'(done),    32'd1);
        chk("gap_err",     0, 32'(err),     32'd0);

        // Maximum count frame (2047 words), sent back-to-back from RUN.
        step(1'b1, 8'hA5, 1'b0);
        chk("max_hdr_cpu_rst", 0, 32'(cpu_rst), 32'd1);
        step(1'b1, 8'h07, 1'b0);
        step(1'b1, 8'hFF, 1'b0);
        acc = 8'h07 ^ 8'hFF;
        for (int i = 0; i < 2047; i++) begin
            word = 14'(i);
            hi   = 8'hC0 | {2'b00, word[13:8]};
            lo   = word[7:0];
            acc  = acc ^ hi ^ lo;
            step(1'b1, hi, 1'b0);
            step(1'b1, lo, 1'b0);
            chk("max_write", i, {6'd0, wr_en, wr_addr, wr_data}, {6'd0, 1'b1, 11'(i), word});
        end
        step(1'b1, acc, 1'b0);
        $display("max frame chk=%h cpu_rst=%0b done=%0b err=%0b last_addr=%0d",
                 acc, cpu_rst, done, err, wr_addr);
        chk("max_cpu_rst", 0, 32'(cpu_rst), 32'd0);
        chk("max_done",    0, 32'(done),    32'd1);
        chk("max_err",     0, 32'(err),     32'd0);
        chk("max_no_wr",   0, 32'(wr_en),   32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
